// File: rtl/alu_multicycle.sv
// Execute-stage ALU. Simple ops complete in one registered cycle; multiply
// and divide run as one-bit-per-cycle engines behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new operation; simple ops complete from here
// MUL   | shift-add multiplier iterating, one multiplier bit per cycle
// DIV   | restoring divider iterating, one quotient bit per cycle
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALU_Control,
   input  logic [WIDTH-1:0] ALU_In1,
   input  logic [WIDTH-1:0] ALU_In2,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALU_Result,
   output logic             Zero,
   output logic             busy
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_t;

   state_t             state;
   logic [SHAMT_W-1:0] iter_cnt;
   logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor
   logic [WIDTH-1:0]   acc_hi;     // product high half / partial remainder
   logic [WIDTH-1:0]   acc_lo;     // multiplier -> product low half / dividend -> quotient
   logic               sel_hi;     // MULHU/REMU take the high half

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   simple_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH-1:0]   hi_nxt;
   logic [WIDTH-1:0]   lo_nxt;
   logic [WIDTH-1:0]   iter_res;

   assign shamt    = ALU_In2[SHAMT_W-1:0];
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Single-cycle result, straight from the ports at accept. The divide
   // entries only matter for a zero divisor, which never enters DIV.
   always_comb begin
      simple_res = '0;
      case (ALU_Control)
         OP_AND:  simple_res = ALU_In1 & ALU_In2;
         OP_OR:   simple_res = ALU_In1 | ALU_In2;
         OP_ADD:  simple_res = ALU_In1 + ALU_In2;
         OP_SUB:  simple_res = ALU_In1 - ALU_In2;
         OP_XOR:  simple_res = ALU_In1 ^ ALU_In2;
         OP_SLL:  simple_res = ALU_In1 << shamt;
         OP_SRL:  simple_res = ALU_In1 >> shamt;
         OP_SRA:  simple_res = $signed(ALU_In1) >>> shamt;
         OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_In1) < $signed(ALU_In2))};
         OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (ALU_In1 < ALU_In2)};
         OP_DIVU: simple_res = '1;
         OP_REMU: simple_res = ALU_In1;
         default: simple_res = '0;
      endcase
   end

   // One iteration of the multiplier or divider, selected by state.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_q};
      hi_nxt    = acc_hi;
      lo_nxt    = acc_lo;
      if (state == MUL) begin
         {hi_nxt, lo_nxt} = {mul_sum, acc_lo[WIDTH-1:1]};
      end else if (state == DIV) begin
         if (!div_trial[WIDTH]) begin
            hi_nxt = div_trial[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
      iter_res = sel_hi ? hi_nxt : lo_nxt;
   end

   // Control FSM, iteration datapath and registered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         iter_cnt   <= '0;
         opnd_q     <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         sel_hi     <= 1'b0;
         out_valid  <= 1'b0;
         ALU_Result <= '0;
         Zero       <= 1'b1;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  iter_cnt <= '0;
                  sel_hi   <= ALU_Control[0];
                  if (ALU_Control == OP_MUL || ALU_Control == OP_MULHU) begin
                     state  <= MUL;
                     opnd_q <= ALU_In1;
                     acc_hi <= '0;
                     acc_lo <= ALU_In2;
                  end else if ((ALU_Control == OP_DIVU || ALU_Control == OP_REMU) &&
                               (ALU_In2 != '0)) begin
                     state  <= DIV;
                     opnd_q <= ALU_In2;
                     acc_hi <= '0;
                     acc_lo <= ALU_In1;
                  end else begin
                     out_valid  <= 1'b1;
                     ALU_Result <= simple_res;
                     Zero       <= (simple_res == '0);
                  end
               end
            end
            MUL, DIV: begin
               acc_hi <= hi_nxt;
               acc_lo <= lo_nxt;
               if (iter_cnt == LAST_ITER) begin
                  state      <= IDLE;
                  iter_cnt   <= '0;
                  out_valid  <= 1'b1;
                  ALU_Result <= iter_res;
                  Zero       <= (iter_res == '0);
               end else begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               iter_cnt <= '0;
            end
         endcase
      end
   end

endmodule
